// File: rtl/sudoku_pkg.sv
// Shared definitions for the 4x4 Sudoku game core and its auto player.
// Cell k sits at row k[3:2], column k[1:0] of the board.
package sudoku_pkg;
    localparam int CELL_W    = 3;
    localparam int NUM_CELLS = 16;
    localparam int VAL_W     = 2;
    localparam int IDX_W     = 4;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_WAIT_DIFF = 4'd1;
    localparam logic [3:0] ST_SCAN      = 4'd2;
    localparam logic [3:0] ST_WAIT_ROW  = 4'd3;
    localparam logic [3:0] ST_WAIT_COL  = 4'd4;
    localparam logic [3:0] ST_WAIT_VAL  = 4'd5;
    localparam logic [3:0] ST_WAIT_FILL = 4'd6;
    localparam logic [3:0] ST_DONE      = 4'd7;
    localparam logic [3:0] ST_ERROR     = 4'd8;

    typedef enum logic [3:0] {
        IDLE      = ST_IDLE,
        WAIT_DIFF = ST_WAIT_DIFF,
        SCAN      = ST_SCAN,
        WAIT_ROW  = ST_WAIT_ROW,
        WAIT_COL  = ST_WAIT_COL,
        WAIT_VAL  = ST_WAIT_VAL,
        WAIT_FILL = ST_WAIT_FILL,
        DONE      = ST_DONE,
        ERROR     = ST_ERROR
    } state_t;

    function automatic logic [VAL_W-1:0] cell_row(
        input logic [IDX_W-1:0] idx
    );
        return idx[3:2];
    endfunction

    function automatic logic [VAL_W-1:0] cell_col(
        input logic [IDX_W-1:0] idx
    );
        return idx[1:0];
    endfunction

    function automatic logic [CELL_W-1:0] cell_val(
        input logic [CELL_W*NUM_CELLS-1:0] board,
        input logic [IDX_W-1:0]            idx
    );
        return board[idx*CELL_W +: CELL_W];
    endfunction
endpackage

// File: rtl/sudoku_cell_scan.sv
// First-unfilled-cell search, one cell per cycle from index 0.
// While start is high the pointer is parked at cell 0; dropping it runs the search.
module sudoku_cell_scan
    import sudoku_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM_CELLS-1:0] fill,
    output logic                 found,
    output logic                 all_full,
    output logic [IDX_W-1:0]     idx
);
    logic [IDX_W-1:0] ptr;

    assign idx      = ptr;
    assign found    = !start && !fill[ptr];
    assign all_full = !start && fill[ptr] &&
                      (ptr == IDX_W'(NUM_CELLS-1));

    always_ff @(posedge clk) begin
        if (!rst_n || start) begin
            ptr <= '0;
        end else if (!found && !all_full) begin
            ptr <= ptr + 1'b1;
        end
    end
endmodule

// File: rtl/sudoku_auto_player.sv
// Auto player: enters difficulty, then row/col/value for each empty
// cell in ascending order, until the core reports the board solved.
module sudoku_auto_player
    import sudoku_pkg::*;
#(
    parameter int GAP_CYCLES = 1,
    parameter int TIMEOUT    = 64
) (
    input  logic                        in_clka,
    input  logic                        in_restart_n,
    input  logic                        in_start,
    input  logic [1:0]                  in_diff,
    input  logic [CELL_W*NUM_CELLS-1:0] in_real_board,
    input  logic [NUM_CELLS-1:0]        in_fill_flag,
    input  logic                        in_set_diff_flag,
    input  logic                        in_row_flag,
    input  logic                        in_col_flag,
    input  logic                        in_val_flag,
    input  logic                        in_solved,
    output logic                        out_enter,
    output logic [VAL_W-1:0]            out_diff_cell_val,
    output logic [IDX_W-1:0]            out_cell_idx,
    output logic                        out_busy,
    output logic                        out_done,
    output logic                        out_error
);
    state_t           state;
    logic [3:0]       gap_cnt;
    logic [7:0]       tmo_cnt;
    logic             has_target;
    logic             scan_found;
    logic             scan_full;
    logic [IDX_W-1:0] scan_idx;
    logic             in_wait;
    logic             flag_seen;
    logic             gap_ok;
    logic             timed_out;
    logic             bad_val;
    logic [CELL_W-1:0] sol;
    logic [CELL_W-1:0] sol_m1;

    sudoku_cell_scan u_scan (
        .clk      (in_clka),
        .rst_n    (in_restart_n),
        .start    (state != SCAN),
        .fill     (in_fill_flag),
        .found    (scan_found),
        .all_full (scan_full),
        .idx      (scan_idx)
    );

    assign sol     = cell_val(in_real_board, out_cell_idx);
    assign sol_m1  = sol - 1'b1;
    assign bad_val = (sol == '0) || (sol > 3'd4);
    assign gap_ok  = (gap_cnt == '0);

    always_comb begin
        in_wait   = 1'b1;
        flag_seen = 1'b0;
        case (state)
            WAIT_DIFF: flag_seen = in_set_diff_flag;
            WAIT_ROW:  flag_seen = in_row_flag;
            WAIT_COL:  flag_seen = in_col_flag;
            WAIT_VAL:  flag_seen = in_val_flag;
            WAIT_FILL: flag_seen = has_target &&
                                   in_fill_flag[out_cell_idx];
            default:   in_wait = 1'b0;
        endcase
    end

    // The timeout only advances while the awaited flag is absent.
    assign timed_out = in_wait && !flag_seen &&
                       (tmo_cnt == 8'(TIMEOUT-1));

    always_ff @(posedge in_clka) begin
        if (!in_restart_n) begin
            state             <= IDLE;
            out_enter         <= 1'b0;
            out_diff_cell_val <= '0;
            out_cell_idx      <= '0;
            out_busy          <= 1'b0;
            out_done          <= 1'b0;
            out_error         <= 1'b0;
            gap_cnt           <= '0;
            tmo_cnt           <= '0;
            has_target        <= 1'b0;
        end else begin
            out_enter         <= 1'b0;
            out_diff_cell_val <= '0;
            if (!gap_ok) gap_cnt <= gap_cnt - 1'b1;
            if (in_wait && !flag_seen) tmo_cnt <= tmo_cnt + 1'b1;
            else tmo_cnt <= '0;

            if (in_wait && in_solved) begin
                state    <= DONE;
                out_busy <= 1'b0;
                out_done <= 1'b1;
            end else if (timed_out) begin
                state     <= ERROR;
                out_busy  <= 1'b0;
                out_error <= 1'b1;
            end else begin
                case (state)
                    IDLE, DONE, ERROR: begin
                        if (in_start) begin
                            state     <= WAIT_DIFF;
                            out_busy  <= 1'b1;
                            out_done  <= 1'b0;
                            out_error <= 1'b0;
                            gap_cnt   <= '0;
                            tmo_cnt   <= '0;
                        end
                    end
                    WAIT_DIFF: begin
                        if (flag_seen && gap_ok) begin
                            out_enter         <= 1'b1;
                            out_diff_cell_val <= in_diff;
                            gap_cnt           <= 4'(GAP_CYCLES);
                            state             <= SCAN;
                        end
                    end
                    SCAN: begin
                        if (scan_found) begin
                            out_cell_idx <= scan_idx;
                            has_target   <= 1'b1;
                            state        <= WAIT_ROW;
                        end else if (scan_full) begin
                            has_target <= 1'b0;
                            state      <= WAIT_FILL;
                        end
                    end
                    WAIT_ROW: begin
                        if (flag_seen && gap_ok) begin
                            out_enter         <= 1'b1;
                            out_diff_cell_val <= cell_row(out_cell_idx);
                            gap_cnt           <= 4'(GAP_CYCLES);
                            state             <= WAIT_COL;
                        end
                    end
                    WAIT_COL: begin
                        if (flag_seen && gap_ok) begin
                            out_enter         <= 1'b1;
                            out_diff_cell_val <= cell_col(out_cell_idx);
                            gap_cnt           <= 4'(GAP_CYCLES);
                            state             <= WAIT_VAL;
                        end
                    end
                    WAIT_VAL: begin
                        if (bad_val) begin
                            state     <= ERROR;
                            out_busy  <= 1'b0;
                            out_error <= 1'b1;
                        end else if (flag_seen && gap_ok) begin
                            out_enter         <= 1'b1;
                            out_diff_cell_val <= sol_m1[VAL_W-1:0];
                            gap_cnt           <= 4'(GAP_CYCLES);
                            state             <= WAIT_FILL;
                        end
                    end
                    WAIT_FILL: begin
                        if (flag_seen) state <= SCAN;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sudoku_auto_player.sv
// Self-checking bench: table of full games against a small core model,
// plus directed sequences for reset, gap, timeout and error corners.
module tb_sudoku_auto_player;
    localparam int GAP = 3;
    localparam int TMO = 8;

    typedef struct {
        logic [1:0] val;
        logic       chk_idx;
        logic [3:0] idx;
    } exp_t;

    typedef struct {
        logic [15:0] fill;
        logic [1:0]  diff;
        int          pulses;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  diff = '0;
    logic [47:0] board = '0;
    logic [47:0] good = '0;
    logic [15:0] fill = '0;
    logic        sdf = 1'b0;
    logic        rf = 1'b0;
    logic        cf = 1'b0;
    logic        vf = 1'b0;
    logic        solved = 1'b0;
    logic        enter;
    logic [1:0]  dcv;
    logic [3:0]  idx;
    logic        busy;
    logic        done;
    logic        error;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   pcnt = 0;
    int   last_pulse = -1;
    int   m_phase = 4;
    int   m_k = 0;
    bit   model_on = 1'b0;
    int   sol_v[16] = '{1, 2, 3, 4, 3, 4, 1, 2, 2, 1, 4, 3, 4, 3, 2, 1};
    exp_t sb[$];
    int   pt[$];
    vec_t vecs[5];
    int   n_done;
    int   p0;

    sudoku_auto_player #(.GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
        .in_clka           (clk),
        .in_restart_n      (rst_n),
        .in_start          (start),
        .in_diff           (diff),
        .in_real_board     (board),
        .in_fill_flag      (fill),
        .in_set_diff_flag  (sdf),
        .in_row_flag       (rf),
        .in_col_flag       (cf),
        .in_val_flag       (vf),
        .in_solved         (solved),
        .out_enter         (enter),
        .out_diff_cell_val (dcv),
        .out_cell_idx      (idx),
        .out_busy          (busy),
        .out_done          (done),
        .out_error         (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic raise_row();
        logic [3:0] kk;
        m_k = 0;
        for (int i = 15; i >= 0; i--) if (!fill[i]) m_k = i;
        kk = 4'(m_k);
        sb.push_back('{val: kk[3:2], chk_idx: 1'b1, idx: kk});
        sb.push_back('{val: kk[1:0], chk_idx: 1'b1, idx: kk});
        sb.push_back('{val: 2'(sol_v[m_k] - 1), chk_idx: 1'b1, idx: kk});
        rf = 1'b1;
        m_phase = 1;
    endtask

    task automatic advance();
        case (m_phase)
            0: begin sdf = 1'b0; raise_row(); end
            1: begin rf = 1'b0; cf = 1'b1; m_phase = 2; end
            2: begin cf = 1'b0; vf = 1'b1; m_phase = 3; end
            3: begin
                vf = 1'b0;
                fill[m_k] = 1'b1;
                if (fill == 16'hFFFF) begin
                    solved = 1'b1;
                    m_phase = 4;
                end else begin
                    raise_row();
                end
            end
            default: ;
        endcase
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (enter) begin
            if (last_pulse >= 0)
                check("gap_min", int'((cyc - last_pulse) >= GAP + 1), 1);
            last_pulse = cyc;
            pt.push_back(cyc);
            pcnt++;
            if (model_on) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_pop: got pulse %0d, want none", dcv);
                end else begin
                    e = sb.pop_front();
                    check("enter_val", int'(dcv), int'(e.val));
                    if (e.chk_idx) check("cell_idx", int'(idx), int'(e.idx));
                end
                advance();
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        {sdf, rf, cf, vf, solved} = '0;
        model_on = 1'b0;
        board = good;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pcnt = 0;
        last_pulse = -1;
        sb.delete();
        pt.delete();
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_game(input vec_t v);
        do_reset();
        fill = v.fill;
        diff = v.diff;
        model_on = 1'b1;
        m_phase = 0;
        sb.push_back('{val: v.diff, chk_idx: 1'b0, idx: 4'd0});
        sdf = 1'b1;
        kick();
        check("game_busy", int'(busy), 1);
        for (int n = 0; n < 2000 && !done && !error; n++) step();
        repeat (10) step();
        check("game_done", int'(done), 1);
        check("game_error", int'(error), 0);
        check("game_pulses", pcnt, v.pulses);
        check("game_sb_left", sb.size(), 0);
    endtask

    initial begin
        vecs[0] = '{fill: 16'hF0F0, diff: 2'b10, pulses: 25};
        vecs[1] = '{fill: 16'hFFFE, diff: 2'b01, pulses: 4};
        vecs[2] = '{fill: 16'h7FFF, diff: 2'b11, pulses: 4};
        vecs[3] = '{fill: 16'hAAAA, diff: 2'b00, pulses: 25};
        vecs[4] = '{fill: 16'h0000, diff: 2'b01, pulses: 49};
        for (int k = 0; k < 16; k++) good[3*k +: 3] = 3'(sol_v[k]);

        do_reset();
        step();
        check("rst_enter", int'(enter), 0);
        check("rst_dcv", int'(dcv), 0);
        check("rst_idx", int'(idx), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_error", int'(error), 0);

        for (int v = 0; v < 5; v++) run_game(vecs[v]);

        // Reset landing on the row-entry pulse.
        do_reset();
        fill = 16'hFFEF;
        sdf = 1'b1;
        rf = 1'b1;
        kick();
        for (int n = 0; n < 40 && pcnt < 2; n++) step();
        check("midrst_pulse", int'(enter), 1);
        check("midrst_row", int'(dcv), 1);
        check("midrst_idx", int'(idx), 4);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_enter", int'(enter), 0);
        check("midrst_outs", int'({busy, done, error, idx, dcv}), 0);
        rst_n = 1'b1;
        p0 = pcnt;
        repeat (20) step();
        check("midrst_quiet", pcnt - p0, 0);
        check("midrst_idle", int'(busy), 0);

        // All flags held high: pulses spaced GAP+1 apart.
        do_reset();
        fill = 16'h0000;
        {sdf, rf, cf, vf} = 4'hF;
        kick();
        for (int n = 0; n < 80 && !error; n++) step();
        check("gap_pulses", pcnt, 4);
        for (int i = 1; i < pt.size(); i++)
            check("gap_space", pt[i] - pt[i-1], GAP + 1);

        // Column flag never arrives.
        do_reset();
        fill = 16'hFFFE;
        sdf = 1'b1;
        rf = 1'b1;
        kick();
        for (int n = 0; n < 40 && pcnt < 2; n++) step();
        check("tmo_row_seen", pcnt, 2);
        repeat (TMO - 1) step();
        check("tmo_early", int'(error), 0);
        step();
        check("tmo_error", int'(error), 1);
        check("tmo_busy", int'(busy), 0);
        kick();
        check("restart_busy", int'(busy), 1);
        check("restart_error", int'(error), 0);

        // Zero solution value at cell 0.
        do_reset();
        board = good & ~48'h7;
        fill = 16'hFFFE;
        {sdf, rf, cf, vf} = 4'hF;
        kick();
        for (int n = 0; n < 60 && !error; n++) step();
        check("badval_error", int'(error), 1);
        check("badval_pulses", pcnt, 3);
        check("badval_done", int'(done), 0);

        // Board already full after the difficulty entry.
        do_reset();
        fill = 16'hFFFF;
        sdf = 1'b1;
        rf = 1'b1;
        kick();
        for (int n = 0; n < 20 && pcnt < 1; n++) step();
        check("full_diff", pcnt, 1);
        solved = 1'b1;
        n_done = 0;
        for (int n = 0; n < 30 && !done; n++) begin
            step();
            n_done++;
        end
        check("full_done", int'(done), 1);
        check("full_latency", int'(n_done <= 17), 1);
        check("full_pulses", pcnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
